// File: rtl/mux_nway_reg.sv
// rtl/mux_nway_reg.sv - registered N-way mux with select and round-robin modes
module mux_nway_reg #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 5,
    parameter int SEL_W  = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        out_src,
    output logic                    err_sel
);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] out_src_q, out_src_d;
    logic             err_sel_q, err_sel_d;
    logic [SEL_W-1:0] last_grant_q, last_grant_d;

    logic             load_en;
    logic             sel_ok;
    logic             grant_any;
    logic [SEL_W-1:0] grant_idx;
    logic [WIDTH-1:0] grant_data;
    int               lg;

    assign load_en = !out_valid_q || out_ready;

    // Pick at most one source: the selected index, or the first valid input after last_grant
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        lg        = int'(last_grant_q);
        sel_ok    = (int'(sel) < NUM_IN);
        if (!mode) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (sel_ok && (int'(sel) == i) && in_valid[i]) begin
                    grant_any = 1'b1;
                    grant_idx = SEL_W'(i);
                end
            end
        end else begin
            for (int k = 1; k <= NUM_IN; k++) begin
                for (int i = 0; i < NUM_IN; i++) begin
                    if (!grant_any && in_valid[i] && (((lg + k) % NUM_IN) == i)) begin
                        grant_any = 1'b1;
                        grant_idx = SEL_W'(i);
                    end
                end
            end
        end
    end

    // Steer the granted word and raise ready only on the granted input; nobody is ready during reset
    always_comb begin
        grant_data = '0;
        in_ready   = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant_any && (grant_idx == SEL_W'(i))) begin
                grant_data  = in_data[i*WIDTH +: WIDTH];
                in_ready[i] = !rst && load_en;
            end
        end
    end

    // Next-state: load on a grant, drain when nothing is granted, hold while stalled
    always_comb begin
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        out_src_d    = out_src_q;
        err_sel_d    = err_sel_q;
        last_grant_d = last_grant_q;
        if (load_en) begin
            if (grant_any) begin
                out_data_d  = grant_data;
                out_src_d   = grant_idx;
                out_valid_d = 1'b1;
                if (mode) begin
                    last_grant_d = grant_idx;
                end
            end else begin
                out_valid_d = 1'b0;
            end
            if (!mode && !sel_ok) begin
                err_sel_d = 1'b1;
            end
        end
    end

    // State registers; reset wins and points the round-robin at input 0 first
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_src_q    <= '0;
            err_sel_q    <= 1'b0;
            last_grant_q <= SEL_W'(NUM_IN - 1);
        end else begin
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_src_q    <= out_src_d;
            err_sel_q    <= err_sel_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_src   = out_src_q;
    assign err_sel   = err_sel_q;

endmodule

// File: tb/tb_mux_nway_reg.sv
// tb/tb_mux_nway_reg.sv - directed self-checking bench for mux_nway_reg
module tb_mux_nway_reg;

    localparam int WIDTH  = 32;
    localparam int NUM_IN = 5;
    localparam int SEL_W  = 3;

    logic                    clk;
    logic                    rst;
    logic                    mode;
    logic [SEL_W-1:0]        sel;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [NUM_IN-1:0]       in_valid;
    logic [NUM_IN-1:0]       in_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [SEL_W-1:0]        out_src;
    logic                    err_sel;
    logic [WIDTH-1:0]        din [NUM_IN];

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < NUM_IN; g++) begin : g_pack
        assign in_data[g*WIDTH +: WIDTH] = din[g];
    end

    mux_nway_reg #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_src   (out_src),
        .err_sel   (err_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] d, input logic [2:0] s);
        chk({tag, "_valid"}, 32'(out_valid), 32'(v));
        chk({tag, "_data"}, out_data, d);
        chk({tag, "_src"}, 32'(out_src), 32'(s));
    endtask

    initial begin
        rst = 1'b1; mode = 1'b0; sel = 3'd0; in_valid = 5'b11111; out_ready = 1'b0;
        for (int i = 0; i < NUM_IN; i++) din[i] = 32'h100 + 32'(i);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        tick();
        chk_out("reset", 1'b0, 32'h0, 3'd0);
        chk("reset_err", 32'(err_sel), 32'h0);

        // select mode single transfer
        rst = 1'b0; sel = 3'd2; din[2] = 32'hDEADBEEF; in_valid = 5'b00100; out_ready = 1'b1;
        #1;
        chk("sel2_in_ready", 32'(in_ready), 32'h04);
        tick();
        chk_out("sel2", 1'b1, 32'hDEADBEEF, 3'd2);
        in_valid = 5'b00000;
        #1;
        chk("idle_in_ready", 32'(in_ready), 32'h0);
        tick();
        chk_out("drain", 1'b0, 32'hDEADBEEF, 3'd2);

        // out-of-range select is sticky
        sel = 3'd5; in_valid = 5'b11111;
        #1;
        chk("sel5_in_ready", 32'(in_ready), 32'h0);
        tick();
        chk("sel5_valid", 32'(out_valid), 32'h0);
        chk("sel5_err", 32'(err_sel), 32'h1);
        sel = 3'd0; in_valid = 5'b00000;
        tick();
        chk("err_sticky", 32'(err_sel), 32'h1);
        rst = 1'b1;
        tick();
        chk("err_cleared", 32'(err_sel), 32'h0);

        // round-robin from reset, all valid
        rst = 1'b0; mode = 1'b1; in_valid = 5'b11111;
        for (int i = 0; i < NUM_IN; i++) din[i] = 32'h10 + 32'(i);
        for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("rr%0d_in_ready", k), 32'(in_ready), 32'h1 << (k % 5));
            tick();
            chk_out($sformatf("rr%0d", k), 1'b1, 32'h10 + 32'(k % 5), 3'(k % 5));
        end

        // sparse valids with wrap: bring last_grant to 3 first
        in_valid = 5'b01000;
        tick();
        chk_out("rr_to3", 1'b1, 32'h13, 3'd3);
        in_valid = 5'b00101;
        #1;
        chk("wrap_in_ready", 32'(in_ready), 32'h01);
        tick();
        chk_out("wrap0", 1'b1, 32'h10, 3'd0);
        chk("then2_in_ready", 32'(in_ready), 32'h04);
        tick();
        chk_out("then2", 1'b1, 32'h12, 3'd2);

        // backpressure in select mode; last_grant stays at 2
        mode = 1'b0; sel = 3'd1; din[1] = 32'hA5A5A5A5; in_valid = 5'b00010;
        tick();
        chk_out("bp_load", 1'b1, 32'hA5A5A5A5, 3'd1);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sel = 3'(k); in_valid = 5'b11111; din[k] = 32'h5000 + 32'(k);
            #1;
            chk($sformatf("bp%0d_in_ready", k), 32'(in_ready), 32'h0);
            tick();
            chk_out($sformatf("bp%0d", k), 1'b1, 32'hA5A5A5A5, 3'd1);
        end
        out_ready = 1'b1; sel = 3'd3; din[3] = 32'h33;
        #1;
        chk("bp_release_in_ready", 32'(in_ready), 32'h08);
        tick();
        chk_out("bp_release", 1'b1, 32'h33, 3'd3);

        // back to round-robin: pointer preserved at 2, so input 3 next
        mode = 1'b1;
        #1;
        chk("rr_resume_in_ready", 32'(in_ready), 32'h08);
        tick();
        chk_out("rr_resume", 1'b1, 32'h33, 3'd3);

        // reset while stalled with err set
        mode = 1'b0; sel = 3'd7;
        tick();
        chk("err_set2", 32'(err_sel), 32'h1);
        chk("err_set2_valid", 32'(out_valid), 32'h0);
        sel = 3'd0; din[0] = 32'h77;
        tick();
        chk_out("pre_rst", 1'b1, 32'h77, 3'd0);
        out_ready = 1'b0; rst = 1'b1;
        #1;
        chk("rst_stall_in_ready", 32'(in_ready), 32'h0);
        tick();
        chk_out("rst_stall", 1'b0, 32'h0, 3'd0);
        chk("rst_stall_err", 32'(err_sel), 32'h0);
        rst = 1'b0; mode = 1'b1; out_ready = 1'b1;
        din[0] = 32'h10;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'h01);
        tick();
        chk_out("post_rst", 1'b1, 32'h10, 3'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
